// File: rtl/ctrl_decode.sv
`default_nettype none
// ctrl_decode: registers one MIPS-I instruction word and classifies it into
// mutually exclusive control classes, one cycle after capture.
module ctrl_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  output logic        Ins_mtdv,
  output logic        Ins_mfhilo,
  output logic        Ins_movto,
  output logic        Ins_movfrom,
  output logic        Ins_eret,
  output logic        Ins_jump,
  output logic        Ins_load,
  output logic        Ins_store,
  output logic        Ins_nop
);

  localparam logic [5:0]  OP_SPECIAL = 6'h00;
  localparam logic [5:0]  OP_REGIMM  = 6'h01;
  localparam logic [5:0]  OP_COP0    = 6'h10;
  localparam logic [4:0]  RS_MF      = 5'h00;
  localparam logic [4:0]  RS_MT      = 5'h04;
  localparam logic [31:0] ERET_WORD  = 32'h4200_0018;

  logic [31:0] instr_q;

  // A word presented while rst is low is dropped; the register reads as nop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q <= 32'h0000_0000;
    end else begin
      instr_q <= instr;
    end
  end

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [5:0] funct;

  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign funct = instr_q[5:0];

  logic is_special;
  logic is_regimm;
  logic is_cop0;

  assign is_special = (op == OP_SPECIAL);
  assign is_regimm  = (op == OP_REGIMM);
  assign is_cop0    = (op == OP_COP0);

  always_comb begin
    Ins_mtdv    = 1'b0;
    Ins_mfhilo  = 1'b0;
    Ins_movto   = 1'b0;
    Ins_movfrom = 1'b0;
    Ins_eret    = 1'b0;
    Ins_jump    = 1'b0;
    Ins_load    = 1'b0;
    Ins_store   = 1'b0;
    Ins_nop     = 1'b0;

    if (is_special) begin
      case (funct)
        6'h18, 6'h19, 6'h1A, 6'h1B, 6'h11, 6'h13: Ins_mtdv   = 1'b1;
        6'h10, 6'h12:                             Ins_mfhilo = 1'b1;
        6'h08, 6'h09:                             Ins_jump   = 1'b1;
        default: ;
      endcase
    end

    if (is_regimm && (rt == 5'h00 || rt == 5'h01)) begin
      Ins_jump = 1'b1;
    end

    case (op)
      6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07: Ins_jump  = 1'b1;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25:        Ins_load  = 1'b1;
      6'h28, 6'h29, 6'h2B:                      Ins_store = 1'b1;
      default: ;
    endcase

    // eret is a cop0 word but its rs (0x10) never collides with mtc0/mfc0.
    Ins_movto   = is_cop0 && (rs == RS_MT);
    Ins_movfrom = is_cop0 && (rs == RS_MF);
    Ins_eret    = (instr_q == ERET_WORD);
    Ins_nop     = (instr_q == 32'h0000_0000);
  end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_decode.sv
`default_nettype none
// tb_ctrl_decode: directed and randomized checks of ctrl_decode against a
// table-driven instruction classifier.
module tb_ctrl_decode;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        Ins_mtdv, Ins_mfhilo, Ins_movto, Ins_movfrom, Ins_eret;
  logic        Ins_jump, Ins_load, Ins_store, Ins_nop;

  int checks = 0;
  int errors = 0;

  // Bit layout: mtdv mfhilo movto movfrom eret jump load store nop
  localparam logic [8:0] V_NONE    = 9'b0_0000_0000;
  localparam logic [8:0] V_MTDV    = 9'b1_0000_0000;
  localparam logic [8:0] V_MFHILO  = 9'b0_1000_0000;
  localparam logic [8:0] V_MOVTO   = 9'b0_0100_0000;
  localparam logic [8:0] V_MOVFROM = 9'b0_0010_0000;
  localparam logic [8:0] V_ERET    = 9'b0_0001_0000;
  localparam logic [8:0] V_JUMP    = 9'b0_0000_1000;
  localparam logic [8:0] V_LOAD    = 9'b0_0000_0100;
  localparam logic [8:0] V_STORE   = 9'b0_0000_0010;
  localparam logic [8:0] V_NOP     = 9'b0_0000_0001;

  logic [8:0] outs;
  assign outs = {Ins_mtdv, Ins_mfhilo, Ins_movto, Ins_movfrom, Ins_eret,
                 Ins_jump, Ins_load, Ins_store, Ins_nop};

  logic [8:0] exp_q;

  ctrl_decode dut (
    .clk(clk), .rst(rst), .instr(instr),
    .Ins_mtdv(Ins_mtdv), .Ins_mfhilo(Ins_mfhilo), .Ins_movto(Ins_movto),
    .Ins_movfrom(Ins_movfrom), .Ins_eret(Ins_eret), .Ins_jump(Ins_jump),
    .Ins_load(Ins_load), .Ins_store(Ins_store), .Ins_nop(Ins_nop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit in_list(input int v, input int lst[$]);
    foreach (lst[i]) if (lst[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Classifier written directly from the instruction-class tables.
  function automatic logic [8:0] ref_vec(input logic [31:0] w);
    int op, rs, rt, fn;
    op = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]); fn = int'(w[5:0]);
    if (w == 32'h0000_0000) return V_NOP;
    if (w == 32'h4200_0018) return V_ERET;
    if (op == 0 && in_list(fn, '{'h18, 'h19, 'h1A, 'h1B, 'h11, 'h13})) return V_MTDV;
    if (op == 0 && in_list(fn, '{'h10, 'h12})) return V_MFHILO;
    if (op == 0 && in_list(fn, '{'h08, 'h09})) return V_JUMP;
    if (op == 'h10 && rs == 4) return V_MOVTO;
    if (op == 'h10 && rs == 0) return V_MOVFROM;
    if (in_list(op, '{2, 3, 4, 5, 6, 7})) return V_JUMP;
    if (op == 1 && (rt == 0 || rt == 1)) return V_JUMP;
    if (in_list(op, '{'h20, 'h21, 'h23, 'h24, 'h25})) return V_LOAD;
    if (in_list(op, '{'h28, 'h29, 'h2B})) return V_STORE;
    return V_NONE;
  endfunction

  // Drive one word at the falling edge and return #1 after the rising edge.
  task automatic step(input logic [31:0] w, input logic r);
    @(negedge clk);
    instr = w;
    rst   = r;
    @(posedge clk);
    #1;
    exp_q = r ? ref_vec(w) : V_NOP;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      step(32'h4200_0018, 1'b0);
      checks++;
      if (outs !== V_NOP) begin
        errors++;
        $display("FAIL reset_cycle%0d: outputs=%b required=%b", i, outs, V_NOP);
      end
      checks++;
      if (Ins_eret !== 1'b0) begin
        errors++;
        $display("FAIL reset_eret%0d: Ins_eret=%b required=0", i, Ins_eret);
      end
    end
  endtask

  task automatic test_eret;
    step(32'h4200_0018, 1'b1);
    checks++;
    if (outs !== V_ERET) begin
      errors++;
      $display("FAIL eret_exact: outputs=%b required=%b", outs, V_ERET);
    end
    step(32'h4200_0019, 1'b1);
    checks++;
    if (outs !== V_NONE) begin
      errors++;
      $display("FAIL eret_near: outputs=%b required=%b", outs, V_NONE);
    end
  endtask

  task automatic test_mtdv_cop0;
    logic [31:0] words [3] = '{32'h0085_0018, 32'h4084_6000, 32'h4004_6000};
    logic [8:0]  vecs  [3] = '{V_MTDV, V_MOVTO, V_MOVFROM};
    for (int i = 0; i < 3; i++) begin
      step(words[i], 1'b1);
      checks++;
      if (outs !== vecs[i]) begin
        errors++;
        $display("FAIL mtdv_cop0_%0d: word=%h outputs=%b required=%b", i, words[i], outs, vecs[i]);
      end
    end
  endtask

  task automatic test_jump;
    logic [31:0] words [4] = '{32'h0800_0C00, 32'h1085_0003, 32'h0400_0002, 32'h03E0_0008};
    for (int i = 0; i < 4; i++) begin
      step(words[i], 1'b1);
      checks++;
      if (outs !== V_JUMP) begin
        errors++;
        $display("FAIL jump_%0d: word=%h outputs=%b required=%b", i, words[i], outs, V_JUMP);
      end
    end
  endtask

  task automatic test_mem;
    logic [31:0] words [4] = '{32'h8C82_0004, 32'hAC82_0004, 32'h0000_4010, 32'h2084_0001};
    logic [8:0]  vecs  [4] = '{V_LOAD, V_STORE, V_MFHILO, V_NONE};
    for (int i = 0; i < 4; i++) begin
      step(words[i], 1'b1);
      checks++;
      if (outs !== vecs[i]) begin
        errors++;
        $display("FAIL mem_%0d: word=%h outputs=%b required=%b", i, words[i], outs, vecs[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic       rs_seq [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [8:0] vecs   [5] = '{V_MOVTO, V_MOVTO, V_NOP, V_MOVTO, V_MOVTO};
    for (int i = 0; i < 5; i++) begin
      step(32'h4084_6000 | 32'(i), rs_seq[i]);
      checks++;
      if (outs !== vecs[i]) begin
        errors++;
        $display("FAIL reset_mid_%0d: outputs=%b required=%b", i, outs, vecs[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    w = 32'h0085_001A;
    step(w, 1'b1);
    for (int i = 0; i < 3; i++) begin
      // Present the next word and confirm the outputs hold until the edge.
      @(negedge clk);
      instr = w;
      rst   = 1'b1;
      #2;
      checks++;
      if (Ins_mtdv !== 1'b1) begin
        errors++;
        $display("FAIL b2b_hold%0d: Ins_mtdv=%b required=1", i, Ins_mtdv);
      end
      @(posedge clk);
      #1;
      checks++;
      if (Ins_mtdv !== 1'b1 || outs !== V_MTDV) begin
        errors++;
        $display("FAIL b2b_edge%0d: outputs=%b required=%b", i, outs, V_MTDV);
      end
    end
    exp_q = V_MTDV;
  endtask

  function automatic logic [31:0] rand_word();
    int pick;
    int ops[$] = '{0, 1, 2, 3, 4, 5, 6, 7, 'h08, 'h0F, 'h10, 'h20, 'h21, 'h22,
                   'h23, 'h24, 'h25, 'h26, 'h28, 'h29, 'h2A, 'h2B, 'h3F};
    int fns[$] = '{'h00, 'h08, 'h09, 'h0C, 'h10, 'h11, 'h12, 'h13, 'h14,
                   'h18, 'h19, 'h1A, 'h1B, 'h1C, 'h20, 'h21};
    logic [31:0] w;
    pick = $urandom_range(0, 19);
    if (pick == 0) return 32'h0000_0000;
    if (pick == 1) return 32'h4200_0018;
    w = $urandom();
    if (pick == 2) return w;
    w[31:26] = 6'(ops[$urandom_range(0, ops.size() - 1)]);
    if (w[31:26] == 6'h00) w[5:0] = 6'(fns[$urandom_range(0, fns.size() - 1)]);
    if (w[31:26] == 6'h10 && pick < 15) w[25:21] = ($urandom_range(0, 1) == 1) ? 5'h04 : 5'h00;
    if (w[31:26] == 6'h01 && pick < 15) w[20:16] = 5'($urandom_range(0, 2));
    return w;
  endfunction

  task automatic test_random;
    logic [31:0] w;
    logic        r;
    for (int i = 0; i < 400; i++) begin
      w = rand_word();
      r = ($urandom_range(0, 19) != 0);
      step(w, r);
      checks++;
      if (outs !== exp_q) begin
        errors++;
        $display("FAIL random_%0d: word=%h rst=%b outputs=%b required=%b", i, w, r, outs, exp_q);
      end
      checks++;
      if ($countones(outs) > 1) begin
        errors++;
        $display("FAIL onehot_%0d: outputs=%b required at most one high", i, outs);
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    instr = 32'h0;
    exp_q = V_NOP;
    test_reset();
    test_eret();
    test_mtdv_cop0();
    test_jump();
    test_mem();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctrl_decode.md
CTRL_DECODE -- requirements
Module: ctrl_decode

Interface
REQ-001 Parameter: none; all encodings are fixed MIPS-I values given below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (rst=0 sampled at a rising clk edge resets).
REQ-004 instr  input  32  instruction word to classify; op=[31:26], rs=[25:21], rt=[20:16], funct=[5:0].
REQ-005 Ins_mtdv  output  1  mult/div-unit write class: op=0x00 with funct 0x18 (mult), 0x19 (multu), 0x1A (div), 0x1B (divu), 0x11 (mthi) or 0x13 (mtlo).
REQ-006 Ins_mfhilo  output  1  op=0x00 with funct 0x10 (mfhi) or 0x12 (mflo).
REQ-007 Ins_movto  output  1  mtc0: op=0x10 and rs=0x04.
REQ-008 Ins_movfrom  output  1  mfc0: op=0x10 and rs=0x00.
REQ-009 Ins_eret  output  1  instr exactly 32'h4200_0018.
REQ-010 Ins_jump  output  1  any control transfer: op 0x02 (j), 0x03 (jal), 0x04 (beq), 0x05 (bne), 0x06 (blez), 0x07 (bgtz); op=0x01 with rt 0x00 (bltz) or 0x01 (bgez); op=0x00 with funct 0x08 (jr) or 0x09 (jalr).
REQ-011 Ins_load  output  1  op 0x20, 0x21, 0x23, 0x24, 0x25 (lb, lh, lw, lbu, lhu).
REQ-012 Ins_store  output  1  op 0x28, 0x29, 0x2B (sb, sh, sw).
REQ-013 Ins_nop  output  1  instr == 32'h0000_0000.

Function
REQ-014 The block SHALL hold one 32-bit instruction register updated from instr at every rising clk edge when rst=1.
REQ-015 Every Ins_* output SHALL be a pure combinational decode of that instruction register, giving exactly one cycle of latency from instr to outputs.
REQ-016 Decode SHALL ignore fields not named in REQ-005..REQ-013 (e.g. rd, shamt, immediate), except Ins_eret and Ins_nop, which compare all 32 bits.
REQ-017 At most one Ins_* output SHALL be high for any instruction word; classes are disjoint by construction.
REQ-018 Any word matching no class (ALU ops, lui, syscall, reserved opcodes, op=0x10 with other rs, regimm with other rt) SHALL drive all Ins_* outputs low.
REQ-019 Outputs SHALL be glitch-free between edges (change only after a rising clk edge), so downstream edge-sensitive logic sees one transition per decoded instruction.
REQ-020 Back-to-back identical instructions SHALL hold the corresponding output high continuously with no low cycle between them.

Reset
REQ-021 When rst=0 at a rising clk edge, the instruction register SHALL load 32'h0000_0000, so after that edge Ins_nop=1 and all other Ins_* outputs are 0.
REQ-022 Reset SHALL take priority over instr capture; a word presented in the reset cycle SHALL be discarded.
REQ-023 The first instruction presented with rst=1 SHALL appear on the outputs after the next rising edge; no additional warm-up cycle.
REQ-024 Reset asserted mid-stream SHALL clear outputs at the next rising edge regardless of the current class.

Verification
REQ-025 rst=0 for 2 cycles with instr=32'h4200_0018 -> Ins_nop=1, Ins_eret=0 and all others 0 after each edge.
REQ-026 rst=1; instr=32'h4200_0018 -> Ins_eret=1 one cycle later; next instr=32'h4200_0019 -> all outputs 0.
REQ-027 instr sequence 32'h0085_0018 (mult), 32'h4084_6000 (mtc0 $4,$12), 32'h4004_6000 (mfc0 $4,$12) -> Ins_mtdv, Ins_movto, Ins_movfrom high in successive cycles, one at a time.
REQ-028 instr 32'h0800_0C00 (j), 32'h1085_0003 (beq), 32'h0400_0002 (bltz), 32'h03E0_0008 (jr $ra) -> Ins_jump=1 for four consecutive cycles.
REQ-029 instr 32'h8C82_0004 (lw), 32'hAC82_0004 (sw), 32'h0000_4010 (mfhi), 32'h2084_0001 (addi) -> Ins_load, Ins_store, Ins_mfhilo, then all outputs 0.
REQ-030 Stream of mtc0 words with rst=0 pulsed in the third cycle -> Ins_movto=1, 1, then 0 with Ins_nop=1 after the reset edge, then Ins_movto=1 again one cycle after rst returns to 1.
